// File: rtl/seven_seg_if.sv
// seven_seg_if: digit data in, scanned anode/segment drive out.
// master = upstream/board side, slave = scanner.
interface seven_seg_if #(
  parameter int NUM_DIGITS = 4
);
  logic [4*NUM_DIGITS-1:0] values;
  logic [NUM_DIGITS-1:0]   digit_en;
  logic [NUM_DIGITS-1:0]   dp_in;
  logic [NUM_DIGITS-1:0]   anode;
  logic [6:0]              segs;
  logic                    dp;
  logic                    digit_tick;

  modport master (
    output values, digit_en, dp_in,
    input  anode, segs, dp, digit_tick
  );

  modport slave (
    input  values, digit_en, dp_in,
    output anode, segs, dp, digit_tick
  );
endinterface

// File: rtl/seven_seg_scanner.sv
// seven_seg_scanner: multiplexed common-anode 7-seg driver.
// Optional macro SEVEN_SEG_LEADING_ZERO_BLANK_EN: blank leading zeros.
module seven_seg_scanner #(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 100000
) (
  input logic       clk,
  input logic       reset,
  seven_seg_if.slave bus
);
  localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(REFRESH_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);

  logic [CW-1:0]         refresh_cnt;
  logic [IW-1:0]         scan_idx;
  logic                  wrap;
  logic                  adv;
  logic [3:0]            nibble;
  logic [6:0]            glyph;
  logic                  show;
  logic [NUM_DIGITS-1:0] lz_blank;
  logic [NUM_DIGITS-1:0] anode_q;
  logic [6:0]            segs_q;
  logic                  dp_q;
  logic                  tick_q;

  assign wrap   = (refresh_cnt == CNT_LAST);
  assign nibble = bus.values[{scan_idx, 2'b00} +: 4];

  // Dwell counter and digit index rotation.
  always_ff @(posedge clk) begin
    if (reset) begin
      refresh_cnt <= '0;
      scan_idx    <= '0;
    end else begin
      refresh_cnt <= wrap ? '0 : refresh_cnt + 1'b1;
      if (wrap)
        scan_idx <= (scan_idx == IDX_LAST) ? '0 : scan_idx + 1'b1;
    end
  end

`ifdef SEVEN_SEG_LEADING_ZERO_BLANK_EN
  // Suppress a zero digit while all enabled higher digits are zero.
  always_comb begin
    logic upper_zero;
    lz_blank   = '0;
    upper_zero = 1'b1;
    for (int j = NUM_DIGITS - 1; j >= 0; j--) begin
      lz_blank[j] = (j != 0) && upper_zero &&
                    (bus.values[4*j +: 4] == 4'h0);
      if (bus.digit_en[j])
        upper_zero = upper_zero &&
                     (bus.values[4*j +: 4] == 4'h0);
    end
  end
`else
  assign lz_blank = '0;
`endif

  assign show = bus.digit_en[scan_idx] && !lz_blank[scan_idx];

  // Active-low hex font, bit 6 = g .. bit 0 = a.
  always_comb begin
    glyph = 7'b1111111;
    unique case (nibble)
      4'h0: glyph = 7'b1000000;
      4'h1: glyph = 7'b1111001;
      4'h2: glyph = 7'b0100100;
      4'h3: glyph = 7'b0110000;
      4'h4: glyph = 7'b0011001;
      4'h5: glyph = 7'b0010010;
      4'h6: glyph = 7'b0000010;
      4'h7: glyph = 7'b1111000;
      4'h8: glyph = 7'b0000000;
      4'h9: glyph = 7'b0010000;
      4'hA: glyph = 7'b0001000;
      4'hB: glyph = 7'b0000011;
      4'hC: glyph = 7'b1000110;
      4'hD: glyph = 7'b0100001;
      4'hE: glyph = 7'b0000110;
      4'hF: glyph = 7'b0001110;
    endcase
  end

  // Registered drive; blanked digits keep their anode strobe.
  always_ff @(posedge clk) begin
    if (reset) begin
      anode_q <= '1;
      segs_q  <= 7'b1111111;
      dp_q    <= 1'b1;
      adv     <= 1'b0;
      tick_q  <= 1'b0;
    end else begin
      anode_q <= ~(NUM_DIGITS'(1) << scan_idx);
      segs_q  <= show ? glyph : 7'b1111111;
      dp_q    <= show ? ~bus.dp_in[scan_idx] : 1'b1;
      adv     <= wrap;
      tick_q  <= adv;
    end
  end

  assign bus.anode      = anode_q;
  assign bus.segs       = segs_q;
  assign bus.dp         = dp_q;
  assign bus.digit_tick = tick_q;
endmodule

// File: tb/tb_seven_seg_scanner.sv
// tb_seven_seg_scanner: vector table + scoreboard bench.
// Covers a 4-digit/4-cycle and a 1-digit/1-cycle build.
module tb_seven_seg_scanner;
  logic clk = 1'b0;
  logic rst_a;
  logic rst_b;

  always #5 clk = ~clk;

  seven_seg_if #(.NUM_DIGITS(4)) if_a ();
  seven_seg_if #(.NUM_DIGITS(1)) if_b ();

  seven_seg_scanner #(
    .NUM_DIGITS(4),
    .REFRESH_DIV(4)
  ) dut_a (
    .clk(clk),
    .reset(rst_a),
    .bus(if_a)
  );

  seven_seg_scanner #(
    .NUM_DIGITS(1),
    .REFRESH_DIV(1)
  ) dut_b (
    .clk(clk),
    .reset(rst_b),
    .bus(if_b)
  );

  typedef struct {
    logic [15:0]      values;
    logic [3:0]       en;
    logic [3:0]       dpi;
    logic [3:0][6:0]  segs;
    logic [3:0]       dpo;
  } vec_t;

  typedef struct {
    logic [3:0] anode;
    logic [6:0] segs;
    logic       dp;
    logic       tick;
  } exp_t;

  vec_t vecs [6];
  exp_t sb [$];
  exp_t blank;
  int errors = 0;
  int checks = 0;

  logic [6:0] glyph_tab [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  task automatic chk(input string name,
                     input logic [15:0] act,
                     input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step_a(input logic r, input exp_t e,
                        input string tag);
    exp_t x;
    rst_a = r;
    sb.push_back(e);
    @(posedge clk);
    @(negedge clk);
    x = sb.pop_front();
    chk({tag, " anode"}, 16'(if_a.anode), 16'(x.anode));
    chk({tag, " segs"}, 16'(if_a.segs), 16'(x.segs));
    chk({tag, " dp"}, 16'(if_a.dp), 16'(x.dp));
    chk({tag, " tick"}, 16'(if_a.digit_tick), 16'(x.tick));
  endtask

  task automatic step_b(input logic r, input exp_t e,
                        input string tag);
    exp_t x;
    rst_b = r;
    sb.push_back(e);
    @(posedge clk);
    @(negedge clk);
    x = sb.pop_front();
    chk({tag, " anode"}, 16'(if_b.anode), 16'(x.anode));
    chk({tag, " segs"}, 16'(if_b.segs), 16'(x.segs));
    chk({tag, " dp"}, 16'(if_b.dp), 16'(x.dp));
    chk({tag, " tick"}, 16'(if_b.digit_tick), 16'(x.tick));
  endtask

  // k counts output cycles since reset release, starting at 1.
  task automatic run_scan(input int row, input int k0,
                          input int k1);
    exp_t e;
    int d;
    logic [3:0] one;
    one = 4'b0001;
    for (int k = k0; k <= k1; k++) begin
      if_a.values   = vecs[row].values;
      if_a.digit_en = vecs[row].en;
      if_a.dp_in    = vecs[row].dpi;
      d = ((k - 1) / 4) % 4;
      e.anode = ~(one << d);
      e.segs  = vecs[row].segs[d];
      e.dp    = vecs[row].dpo[d];
      e.tick  = (k > 1) && (((k - 1) % 4) == 0);
      step_a(1'b0, e, $sformatf("r%0d k%0d", row, k));
    end
  endtask

  initial begin
    exp_t eb;
    blank = '{anode: 4'hF, segs: 7'h7F, dp: 1'b1, tick: 1'b0};

    vecs[0] = '{16'hF9A0, 4'b1111, 4'b0000,
      {7'b0001110, 7'b0010000, 7'b0001000, 7'b1000000},
      4'b1111};
    vecs[1] = '{16'h1234, 4'b1011, 4'b0010,
      {7'b1111001, 7'b1111111, 7'b0110000, 7'b0011001},
      4'b1101};
`ifdef SEVEN_SEG_LEADING_ZERO_BLANK_EN
    vecs[2] = '{16'h0050, 4'b1111, 4'b0000,
      {7'b1111111, 7'b1111111, 7'b0010010, 7'b1000000},
      4'b1111};
`else
    vecs[2] = '{16'h0050, 4'b1111, 4'b0000,
      {7'b1000000, 7'b1000000, 7'b0010010, 7'b1000000},
      4'b1111};
`endif
    vecs[3] = '{16'hB6D8, 4'b1111, 4'b1001,
      {7'b0000011, 7'b0000010, 7'b0100001, 7'b0000000},
      4'b0110};
    vecs[4] = '{16'h7CE2, 4'b1111, 4'b0000,
      {7'b1111000, 7'b1000110, 7'b0000110, 7'b0100100},
      4'b1111};
`ifdef SEVEN_SEG_LEADING_ZERO_BLANK_EN
    vecs[5] = '{16'h0000, 4'b0111, 4'b0111,
      {7'b1111111, 7'b1111111, 7'b1111111, 7'b1000000},
      4'b1110};
`else
    vecs[5] = '{16'h0000, 4'b0111, 4'b0111,
      {7'b1111111, 7'b1000000, 7'b1000000, 7'b1000000},
      4'b1000};
`endif

    rst_a = 1'b1;
    rst_b = 1'b1;
    if_a.values   = vecs[0].values;
    if_a.digit_en = vecs[0].en;
    if_a.dp_in    = vecs[0].dpi;
    if_b.values   = 4'h0;
    if_b.digit_en = 1'b1;
    if_b.dp_in    = 1'b0;

    for (int i = 0; i < 3; i++)
      step_a(1'b1, blank, $sformatf("reset%0d", i));

    for (int r = 0; r < 6; r++) begin
      if (r > 0)
        step_a(1'b1, blank, $sformatf("rst r%0d", r));
      run_scan(r, 1, 17);
    end

    step_a(1'b1, blank, "pre mid");
    run_scan(0, 1, 10);
    step_a(1'b1, blank, "mid reset");
    run_scan(0, 1, 5);

    step_a(1'b1, blank, "pre swap");
    run_scan(0, 1, 4);
    run_scan(4, 5, 8);
    run_scan(3, 9, 9);

    eb = '{anode: 4'h1, segs: 7'h7F, dp: 1'b1, tick: 1'b0};
    step_b(1'b1, eb, "b reset");
    for (int i = 0; i < 16; i++) begin
      if_b.values = 4'(i);
      eb.anode = 4'h0;
      eb.segs  = glyph_tab[i];
      eb.dp    = 1'b1;
      eb.tick  = (i >= 1);
      step_b(1'b0, eb, $sformatf("b v%0d", i));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
